// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive buffer.
package uart_rx_pkg;

    typedef logic [7:0] byte_t;

    localparam int UART_FIFO_DEPTH_LOG2_DEF = 4;
    localparam logic [7:0] ERRCNT_MAX = 8'd255;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO with extra-MSB pointers.
// A write while full is taken only when a pop frees the head slot in the same cycle.
module sync_fifo #(
    parameter int DW = 8,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    output logic [DW-1:0] rd_data,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   level
);

    localparam int DEPTH = 1 << AW;

    logic [DW-1:0] mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic          do_wr;
    logic          do_rd;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign level = wr_ptr - rd_ptr;

    assign do_rd = rd_en & ~empty;
    assign do_wr = wr_en & (~full | do_rd);

    // Head reads as zero when empty so the output is defined out of reset.
    assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// Frame-end capture, error filtering and buffering of UART receiver bytes.
// Define UART_RX_ERRCNT_EN to add saturating parity/stop-bit error counters.
module uart_rx_fifo
    import uart_rx_pkg::*;
#(
    parameter int DEPTH_LOG2 = UART_FIFO_DEPTH_LOG2_DEF,
    parameter bit DROP_ERR   = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [7:0]            rx_data,
    input  logic                  rx_rdsig,
    input  logic                  rx_dataerror,
    input  logic                  rx_frameerror,
    output logic [7:0]            m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DEPTH_LOG2:0]   fifo_level,
`ifdef UART_RX_ERRCNT_EN
    input  logic                  cnt_clr,
    output logic [7:0]            par_err_cnt,
    output logic [7:0]            frm_err_cnt,
`endif
    input  logic                  ovf_clr,
    output logic                  overflow
);

    logic  rdsig_q;
    logic  armed;
    logic  fall;
    logic  bad;
    logic  wr_req;
    logic  rd;
    logic  full;
    logic  empty;
    byte_t head;

    // Error flags settle only after rdsig rises, so capture waits for its fall.
    // armed keeps a frame already in flight at reset release from being taken.
    assign fall   = armed & rdsig_q & ~rx_rdsig;
    assign bad    = DROP_ERR & (rx_dataerror | rx_frameerror);
    assign wr_req = fall & ~bad;
    assign rd     = m_valid & m_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdsig_q <= 1'b0;
            armed   <= 1'b0;
        end else begin
            rdsig_q <= rx_rdsig;
            armed   <= armed | ~rx_rdsig;
        end
    end

    sync_fifo #(
        .DW (8),
        .AW (DEPTH_LOG2)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_req),
        .wr_data (rx_data),
        .rd_en   (rd),
        .rd_data (head),
        .full    (full),
        .empty   (empty),
        .level   (fifo_level)
    );

    assign m_data  = head;
    assign m_valid = ~empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (wr_req & full & ~rd) begin
            overflow <= 1'b1;
        end else if (ovf_clr) begin
            overflow <= 1'b0;
        end
    end

`ifdef UART_RX_ERRCNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_err_cnt <= 8'd0;
            frm_err_cnt <= 8'd0;
        end else if (cnt_clr) begin
            par_err_cnt <= 8'd0;
            frm_err_cnt <= 8'd0;
        end else if (fall) begin
            if (rx_dataerror && par_err_cnt != ERRCNT_MAX)
                par_err_cnt <= par_err_cnt + 8'd1;
            if (rx_frameerror && frm_err_cnt != ERRCNT_MAX)
                frm_err_cnt <= frm_err_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench: two instances (DROP_ERR=1 and DROP_ERR=0) against a queue model.
module tb_uart_rx_fifo;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] rx_data;
    logic       rx_rdsig;
    logic       rx_de;
    logic       rx_fe;
    logic       m_ready;
    logic       ovf_clr;

    logic [7:0] m_data_o  [2];
    logic       m_valid_o [2];
    logic [4:0] lvl_o     [2];
    logic       ovf_o     [2];

`ifdef UART_RX_ERRCNT_EN
    logic       cnt_clr;
    logic [7:0] par_o [2];
    logic [7:0] frm_o [2];
    int         mpar;
    int         mfrm;
`endif

    int tests = 0;
    int fails = 0;

    logic [7:0] mq [2][$];
    bit         movf [2];
    bit         seen_low;
    bit         prev_rd;

    always #5 clk = ~clk;

    // Instance 0 drops errored bytes, instance 1 stores everything.
    uart_rx_fifo #(.DEPTH_LOG2(4), .DROP_ERR(1'b1)) dut_drop (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_rdsig(rx_rdsig),
        .rx_dataerror(rx_de), .rx_frameerror(rx_fe),
        .m_data(m_data_o[0]), .m_valid(m_valid_o[0]), .m_ready(m_ready),
        .fifo_level(lvl_o[0]),
`ifdef UART_RX_ERRCNT_EN
        .cnt_clr(cnt_clr), .par_err_cnt(par_o[0]), .frm_err_cnt(frm_o[0]),
`endif
        .ovf_clr(ovf_clr), .overflow(ovf_o[0])
    );

    uart_rx_fifo #(.DEPTH_LOG2(4), .DROP_ERR(1'b0)) dut_keep (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_rdsig(rx_rdsig),
        .rx_dataerror(rx_de), .rx_frameerror(rx_fe),
        .m_data(m_data_o[1]), .m_valid(m_valid_o[1]), .m_ready(m_ready),
        .fifo_level(lvl_o[1]),
`ifdef UART_RX_ERRCNT_EN
        .cnt_clr(cnt_clr), .par_err_cnt(par_o[1]), .frm_err_cnt(frm_o[1]),
`endif
        .ovf_clr(ovf_clr), .overflow(ovf_o[1])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic compare_all();
        for (int i = 0; i < 2; i++) begin
            check($sformatf("valid%0d", i), 32'(m_valid_o[i]), 32'(mq[i].size() > 0));
            check($sformatf("level%0d", i), 32'(lvl_o[i]), 32'(mq[i].size()));
            check($sformatf("ovf%0d", i), 32'(ovf_o[i]), 32'(movf[i]));
            if (mq[i].size() > 0)
                check($sformatf("data%0d", i), 32'(m_data_o[i]), 32'(mq[i][0]));
`ifdef UART_RX_ERRCNT_EN
            check($sformatf("parcnt%0d", i), 32'(par_o[i]), 32'(mpar));
            check($sformatf("frmcnt%0d", i), 32'(frm_o[i]), 32'(mfrm));
`endif
        end
    endtask

    // One clock: update the model with the inputs the DUT samples, then compare.
    task automatic tick();
        bit fall;
        bit pop;
        bit was_full;
        bit good;
        bit set;
        @(posedge clk);
        fall = seen_low && prev_rd && !rx_rdsig;
        for (int i = 0; i < 2; i++) begin
            pop      = m_ready && (mq[i].size() > 0);
            was_full = (mq[i].size() == 16);
            good     = (i == 1) || !(rx_de || rx_fe);
            set      = fall && good && was_full && !pop;
            if (pop) void'(mq[i].pop_front());
            if (fall && good && (!was_full || pop)) mq[i].push_back(rx_data);
            if (set) movf[i] = 1'b1;
            else if (ovf_clr) movf[i] = 1'b0;
        end
`ifdef UART_RX_ERRCNT_EN
        if (cnt_clr) begin
            mpar = 0;
            mfrm = 0;
        end else if (fall) begin
            if (rx_de && mpar < 255) mpar++;
            if (rx_fe && mfrm < 255) mfrm++;
        end
`endif
        if (!rx_rdsig) seen_low = 1'b1;
        prev_rd = rx_rdsig;
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("rst_valid%0d", i), 32'(m_valid_o[i]), 32'd0);
            check($sformatf("rst_level%0d", i), 32'(lvl_o[i]), 32'd0);
            check($sformatf("rst_ovf%0d", i), 32'(ovf_o[i]), 32'd0);
            check($sformatf("rst_data%0d", i), 32'(m_data_o[i]), 32'd0);
        end
        for (int i = 0; i < 2; i++) begin
            mq[i].delete();
            movf[i] = 1'b0;
        end
        seen_low = 1'b0;
        prev_rd  = 1'b0;
`ifdef UART_RX_ERRCNT_EN
        mpar = 0;
        mfrm = 0;
`endif
        #18;
        rst_n = 1'b1;
    endtask

    // rdsig high for three cycles (flags raised late), then the fall cycle.
    task automatic send_frame(input logic [7:0] d, input bit de, input bit fe, input bit rdy_fall);
        bit saved;
        rx_data  = d;
        rx_rdsig = 1'b1;
        tick();
        tick();
        rx_de = de;
        rx_fe = fe;
        tick();
        rx_rdsig = 1'b0;
        saved = m_ready;
        if (rdy_fall) m_ready = 1'b1;
        tick();
        m_ready = saved;
        rx_de   = 1'b0;
        rx_fe   = 1'b0;
    endtask

    initial begin
        rst_n    = 1'b0;
        rx_data  = 8'h00;
        rx_rdsig = 1'b0;
        rx_de    = 1'b0;
        rx_fe    = 1'b0;
        m_ready  = 1'b1;
        ovf_clr  = 1'b0;
`ifdef UART_RX_ERRCNT_EN
        cnt_clr  = 1'b0;
`endif
        @(posedge clk);
        #1;

        // Single good frame, one-cycle latency, then drained.
        do_reset();
        tick();
        send_frame(8'hA5, 1'b0, 1'b0, 1'b0);
        check("lat_valid", 32'(m_valid_o[0]), 32'd1);
        check("lat_data", 32'(m_data_o[0]), 32'hA5);
        tick();
        check("drain_level", 32'(lvl_o[0]), 32'd0);

        // Parity-error byte: dropped by instance 0, kept by instance 1.
        send_frame(8'h3C, 1'b1, 1'b0, 1'b0);
        check("drop_level", 32'(lvl_o[0]), 32'd0);
        check("keep_valid", 32'(m_valid_o[1]), 32'd1);
        check("keep_data", 32'(m_data_o[1]), 32'h3C);
        tick();

        // Overflow: 17 frames into a stalled 16-entry FIFO.
        do_reset();
        m_ready = 1'b0;
        tick();
        for (int i = 0; i <= 16; i++) send_frame(8'(i), 1'b0, 1'b0, 1'b0);
        tick();
        check("full_level", 32'(lvl_o[0]), 32'd16);
        check("ovf_set", 32'(ovf_o[0]), 32'd1);
        m_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check("order0", 32'(m_data_o[0]), 32'(i));
            check("order1", 32'(m_data_o[1]), 32'(i));
            tick();
        end
        check("empty_after_drain", 32'(m_valid_o[0]), 32'd0);
        check("ovf_sticky", 32'(ovf_o[1]), 32'd1);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check("ovf_clr", 32'(ovf_o[0]), 32'd0);

        // Full FIFO, fall coincides with a pop: byte accepted, no overflow.
        m_ready = 1'b0;
        for (int i = 0; i < 16; i++) send_frame(8'(8'h80 + i), 1'b0, 1'b0, 1'b0);
        send_frame(8'h99, 1'b0, 1'b0, 1'b1);
        check("full_pop_level", 32'(lvl_o[0]), 32'd16);
        check("full_pop_ovf", 32'(ovf_o[0]), 32'd0);
        check("full_pop_head", 32'(m_data_o[0]), 32'h81);
        m_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (i == 15) check("full_pop_tail", 32'(m_data_o[0]), 32'h99);
            tick();
        end

        // Reset released mid-frame: that frame is ignored, the next is taken.
        rx_data  = 8'hEE;
        rx_rdsig = 1'b1;
        do_reset();
        tick();
        tick();
        rx_rdsig = 1'b0;
        tick();
        check("midframe_level", 32'(lvl_o[0]), 32'd0);
        check("midframe_valid", 32'(m_valid_o[1]), 32'd0);
        send_frame(8'h5A, 1'b0, 1'b0, 1'b0);
        check("next_valid", 32'(m_valid_o[0]), 32'd1);
        check("next_data", 32'(m_data_o[0]), 32'h5A);
        tick();

        // Randomized traffic: data, error flags, back-pressure and clears.
        for (int n = 0; n < 250; n++) begin
            m_ready = 1'($urandom_range(0, 3) != 0 ? (n % 64 < 40 ? 0 : 1) : $urandom_range(0, 1));
            ovf_clr = ($urandom_range(0, 15) == 0);
            send_frame(8'($urandom), $urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0,
                       1'($urandom_range(0, 1)));
            ovf_clr = 1'b0;
            for (int g = $urandom_range(0, 2); g > 0; g--) begin
                m_ready = 1'($urandom_range(0, 1));
                tick();
            end
        end
        m_ready = 1'b1;
        for (int i = 0; i < 20; i++) tick();

`ifdef UART_RX_ERRCNT_EN
        // Frame-error counter saturates; clear zeroes both counters.
        do_reset();
        tick();
        for (int i = 0; i < 300; i++) send_frame(8'(i), 1'b0, 1'b1, 1'b0);
        tick();
        check("frm_sat", 32'(frm_o[0]), 32'd255);
        check("par_zero", 32'(par_o[1]), 32'd0);
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        check("frm_clr", 32'(frm_o[1]), 32'd0);
        check("par_clr", 32'(par_o[0]), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
